// File: rtl/ll_fifo_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ll_fifo_scheduler
// Description : Push/pop scheduler in front of a shared linked-list FIFO that
//               holds NUM_FIFOS logical queues in DEPTH entries. Producers are
//               admitted by a round-robin push arbiter with a per-queue quota.
//               A round-robin pop arbiter drains the queues into a single
//               registered output stage.
// Ports       : clk, rst (async, active-low)
//               in_valid/in_data/in_ready         producer side (in_ready comb.)
//               out_valid/out_data/out_sel/out_ready consumer side (registered)
//               ll_push/ll_push_sel/ll_data_in    push command to shared FIFO
//               ll_pop/ll_pop_sel                 pop command to shared FIFO
//               ll_full/ll_empty/ll_data_out      status/head data from FIFO
//               occ                               per-queue occupancy counters
// Revision    : 1.0 - initial release
// ============================================================================
module ll_fifo_scheduler #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int QUOTA     = DEPTH - 1,
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_FIFOS-1:0]           in_valid,
    input  logic [NUM_FIFOS*WIDTH-1:0]     in_data,
    output logic [NUM_FIFOS-1:0]           in_ready,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    output logic [SEL_WIDTH-1:0]           out_sel,
    input  logic                           out_ready,
    output logic                           ll_push,
    output logic                           ll_pop,
    output logic [SEL_WIDTH-1:0]           ll_push_sel,
    output logic [SEL_WIDTH-1:0]           ll_pop_sel,
    output logic [WIDTH-1:0]               ll_data_in,
    input  logic                           ll_full,
    input  logic [NUM_FIFOS-1:0]           ll_empty,
    input  logic [WIDTH-1:0]               ll_data_out,
    output logic [NUM_FIFOS*CNT_WIDTH-1:0] occ
);

    localparam logic [SEL_WIDTH:0]   c_num_fifos = (SEL_WIDTH + 1)'(NUM_FIFOS);
    localparam logic [SEL_WIDTH-1:0] c_last_sel  = SEL_WIDTH'(NUM_FIFOS - 1);
    localparam logic [CNT_WIDTH-1:0] c_quota     = CNT_WIDTH'(QUOTA);

    logic [SEL_WIDTH-1:0] r_push_ptr;
    logic [SEL_WIDTH-1:0] r_pop_ptr;
    logic [CNT_WIDTH-1:0] r_occ [NUM_FIFOS];
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic [SEL_WIDTH-1:0] r_out_sel;

    logic [NUM_FIFOS-1:0] w_push_req;
    logic [NUM_FIFOS-1:0] w_pop_req;
    logic [WIDTH-1:0]     w_in_word [NUM_FIFOS];
    logic [SEL_WIDTH:0]   w_push_pick;
    logic [SEL_WIDTH:0]   w_pop_pick;
    logic                 w_pop_slot;

    // Round-robin pick: returns {valid, index} of the first requester at or
    // after ptr. The search runs backwards so the closest requester is the
    // last one written and therefore wins.
    function automatic logic [SEL_WIDTH:0] rr_pick(
        input logic [NUM_FIFOS-1:0] req,
        input logic [SEL_WIDTH-1:0] ptr
    );
        logic [SEL_WIDTH:0] idx;
        logic [SEL_WIDTH:0] res;
        res = '0;
        for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (SEL_WIDTH + 1)'(k);
            if (idx >= c_num_fifos) begin
                idx = idx - c_num_fifos;
            end
            if (req[idx[SEL_WIDTH-1:0]]) begin
                res = {1'b1, idx[SEL_WIDTH-1:0]};
            end
        end
        return res;
    endfunction

    function automatic logic [SEL_WIDTH-1:0] ptr_after(input logic [SEL_WIDTH-1:0] sel);
        return (sel == c_last_sel) ? '0 : sel + 1'b1;
    endfunction

    // A pop may be issued whenever the output register is free or is being
    // drained this cycle; this is what gives back-to-back output throughput.
    assign w_pop_slot = ~r_out_valid | out_ready;

    // Requests are qualified with rst so that no push or pop command reaches
    // the shared FIFO while it is held in reset.
    generate
        for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_queue
            assign w_in_word[i]  = in_data[i*WIDTH +: WIDTH];
            assign w_push_req[i] = rst & in_valid[i] & (r_occ[i] < c_quota) & ~ll_full;
            assign w_pop_req[i]  = rst & w_pop_slot & ~ll_empty[i];
            assign occ[i*CNT_WIDTH +: CNT_WIDTH] = r_occ[i];
        end
    endgenerate

    assign w_push_pick = rr_pick(w_push_req, r_push_ptr);
    assign w_pop_pick  = rr_pick(w_pop_req, r_pop_ptr);

    assign ll_push     = w_push_pick[SEL_WIDTH];
    assign ll_push_sel = w_push_pick[SEL_WIDTH-1:0];
    assign ll_data_in  = ll_push ? w_in_word[ll_push_sel] : '0;
    assign ll_pop      = w_pop_pick[SEL_WIDTH];
    assign ll_pop_sel  = w_pop_pick[SEL_WIDTH-1:0];

    always_comb begin
        in_ready = '0;
        if (ll_push) begin
            in_ready[ll_push_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_push_ptr  <= '0;
            r_pop_ptr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            for (int i = 0; i < NUM_FIFOS; i++) begin
                r_occ[i] <= '0;
            end
        end else begin
            if (ll_push) begin
                r_push_ptr <= ptr_after(ll_push_sel);
            end
            if (ll_pop) begin
                r_pop_ptr   <= ptr_after(ll_pop_sel);
                r_out_valid <= 1'b1;
                r_out_data  <= ll_data_out;
                r_out_sel   <= ll_pop_sel;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Push and pop of the same queue cancel, leaving occ unchanged.
            for (int i = 0; i < NUM_FIFOS; i++) begin
                r_occ[i] <= r_occ[i]
                          + CNT_WIDTH'(ll_push && (ll_push_sel == SEL_WIDTH'(i)))
                          - CNT_WIDTH'(ll_pop  && (ll_pop_sel  == SEL_WIDTH'(i)));
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_ll_fifo_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ll_fifo_scheduler
// Description : Directed self-checking bench for ll_fifo_scheduler with the
//               default parameters (WIDTH=8, DEPTH=4, NUM_FIFOS=2, QUOTA=3).
//               A small behavioural model stands in for the shared
//               linked-list FIFO; invariants are checked every negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ll_fifo_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [0:0]  out_sel;
    logic        out_ready;
    logic        ll_push;
    logic        ll_pop;
    logic [0:0]  ll_push_sel;
    logic [0:0]  ll_pop_sel;
    logic [7:0]  ll_data_in;
    logic        ll_full;
    logic [1:0]  ll_empty;
    logic [7:0]  ll_data_out;
    logic [5:0]  occ;

    int tests_run    = 0;
    int tests_failed = 0;

    ll_fifo_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sel     (out_sel),
        .out_ready   (out_ready),
        .ll_push     (ll_push),
        .ll_pop      (ll_pop),
        .ll_push_sel (ll_push_sel),
        .ll_pop_sel  (ll_pop_sel),
        .ll_data_in  (ll_data_in),
        .ll_full     (ll_full),
        .ll_empty    (ll_empty),
        .ll_data_out (ll_data_out),
        .occ         (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared linked-list FIFO model ----------------
    logic [7:0] fdata [2][4];
    int         fcnt  [2];
    logic       m_pop_same;

    assign ll_empty[0]  = (fcnt[0] == 0);
    assign ll_empty[1]  = (fcnt[1] == 0);
    assign ll_full      = ((fcnt[0] + fcnt[1]) == 4);
    assign ll_data_out  = fdata[ll_pop_sel][0];
    assign m_pop_same   = ll_push && ll_pop && (ll_push_sel == ll_pop_sel);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt[0] <= 0;
            fcnt[1] <= 0;
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (ll_pop && int'(ll_pop_sel) == q) begin
                    for (int k = 0; k < 3; k++) fdata[q][k] <= fdata[q][k+1];
                end
                fcnt[q] <= fcnt[q] + ((ll_push && int'(ll_push_sel) == q) ? 1 : 0)
                                   - ((ll_pop  && int'(ll_pop_sel)  == q) ? 1 : 0);
            end
            if (ll_push && (fcnt[ll_push_sel] - int'(m_pop_same)) >= 0
                        && (fcnt[ll_push_sel] - int'(m_pop_same)) < 4) begin
                fdata[ll_push_sel][fcnt[ll_push_sel] - int'(m_pop_same)] <= ll_data_in;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] occ_of(input int i);
        return occ[i*3 +: 3];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check_eq("inv_empty_occ0", ll_empty[0], occ_of(0) == 3'd0);
            check_eq("inv_empty_occ1", ll_empty[1], occ_of(1) == 3'd0);
            check_eq("inv_occ0_model", occ_of(0), fcnt[0]);
            check_eq("inv_occ1_model", occ_of(1), fcnt[1]);
            check_eq("inv_sum_le_depth", (occ_of(0) + occ_of(1)) <= 4, 1);
            check_eq("inv_full_sum", ll_full, (occ_of(0) + occ_of(1)) == 4);
            check_eq("inv_pop_nonempty", ll_pop & ll_empty[ll_pop_sel], 0);
            check_eq("inv_push_not_full", ll_push & ll_full, 0);
            check_eq("inv_in_ready_onehot0", $onehot0(in_ready), 1);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] exp_data [4];
    logic       exp_sel  [4];

    initial begin
        rst       = 1'b0;
        in_valid  = 2'b00;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, including grant suppression while rst is low.
        check_eq("rst_occ", occ, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_sel", out_sel, 0);
        in_valid = 2'b11;
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_ll_push", ll_push, 0);
        check_eq("rst_ll_pop", ll_pop, 0);
        in_valid = 2'b00;
        #1;
        rst = 1'b1;
        tick;

        // Phase 1: both producers valid, consumer stalled. The first word
        // drains into the empty output register, so five grants fill the
        // store: 0,1,0,1,0.
        for (int k = 0; k < 5; k++) begin
            in_valid = 2'b11;
            in_data  = {8'hB0 + 8'(k), 8'hA0 + 8'(k)};
            #1;
            check_eq("p1_in_ready", in_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            check_eq("p1_ll_data_in", ll_data_in, (k % 2 == 0) ? 8'hA0 + 8'(k) : 8'hB0 + 8'(k));
            check_eq("p1_ll_pop", ll_pop, (k == 1) ? 1 : 0);
            tick;
        end
        #1;
        check_eq("p1_full", ll_full, 1);
        check_eq("p1_in_ready_full", in_ready, 2'b00);
        check_eq("p1_ll_push_full", ll_push, 0);
        check_eq("p1_occ0", occ_of(0), 2);
        check_eq("p1_occ1", occ_of(1), 2);

        // Stall: output register held, no pop.
        for (int k = 0; k < 3; k++) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_data", out_data, 8'hA0);
            check_eq("stall_sel", out_sel, 0);
            check_eq("stall_ll_pop", ll_pop, 0);
            tick;
        end

        // Release: accept and pop in the same cycle, then drain in RR order.
        in_valid  = 2'b00;
        out_ready = 1'b1;
        #1;
        check_eq("rel_ll_pop", ll_pop, 1);
        check_eq("rel_ll_pop_sel", ll_pop_sel, 1);
        exp_data[0] = 8'hB1; exp_sel[0] = 1'b1;
        exp_data[1] = 8'hA2; exp_sel[1] = 1'b0;
        exp_data[2] = 8'hB3; exp_sel[2] = 1'b1;
        exp_data[3] = 8'hA4; exp_sel[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            check_eq("drain1_valid", out_valid, 1);
            check_eq("drain1_data", out_data, exp_data[k]);
            check_eq("drain1_sel", out_sel, exp_sel[k]);
        end
        tick;
        check_eq("drain1_empty", out_valid, 0);
        check_eq("drain1_occ", occ, 0);

        // Phase 2: park one word from queue 1 in the output register, then
        // only producer 0 pushes against its quota.
        out_ready = 1'b0;
        in_valid  = 2'b10;
        in_data   = {8'hC1, 8'h00};
        #1;
        check_eq("p2_prime_in_ready", in_ready, 2'b10);
        tick;
        in_valid = 2'b00;
        #1;
        check_eq("p2_prime_pop_sel", ll_pop_sel, 1);
        tick;
        check_eq("p2_prime_data", out_data, 8'hC1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 2'b01;
            in_data  = {8'h00, 8'hD0 + 8'(k)};
            #1;
            check_eq("p2_in_ready", in_ready, (k < 3) ? 2'b01 : 2'b00);
            check_eq("p2_not_full", ll_full, 0);
            tick;
            check_eq("p2_occ0", occ_of(0), (k < 3) ? 3'(k + 1) : 3'd3);
        end
        in_valid = 2'b00;
        check_eq("p2_held_data", out_data, 8'hC1);

        out_ready = 1'b1;
        #1;
        check_eq("drain2_pop_sel", ll_pop_sel, 0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check_eq("drain2_data", out_data, 8'hD0 + 8'(k));
            check_eq("drain2_sel", out_sel, 0);
        end
        tick;
        check_eq("drain2_empty", out_valid, 0);

        // Phase 3: A,B to queue 0 and C to queue 1 -> out A, C, B.
        in_valid = 2'b01;
        in_data  = {8'h00, 8'h0A};
        #1;
        check_eq("p3_grant_a", in_ready, 2'b01);
        check_eq("p3_no_pop", ll_pop, 0);
        tick;
        in_valid = 2'b11;
        in_data  = {8'h0C, 8'h0B};
        #1;
        check_eq("p3_grant_c", in_ready, 2'b10);
        check_eq("p3_first_pop", ll_pop, 1);
        check_eq("p3_first_pop_sel", ll_pop_sel, 0);
        check_eq("p3_valid_before", out_valid, 0);
        tick;
        check_eq("p3_out_a_valid", out_valid, 1);
        check_eq("p3_out_a", {out_sel, out_data}, {1'b0, 8'h0A});
        in_valid = 2'b01;
        in_data  = {8'h00, 8'h0B};
        #1;
        check_eq("p3_grant_b", in_ready, 2'b01);
        tick;
        in_valid = 2'b00;
        check_eq("p3_out_c", {out_sel, out_data}, {1'b1, 8'h0C});
        tick;
        check_eq("p3_out_b", {out_sel, out_data}, {1'b0, 8'h0B});
        tick;
        check_eq("p3_done", out_valid, 0);

        // Phase 4: same-cycle push and pop on queue 0 holding one entry.
        out_ready = 1'b0;
        in_valid  = 2'b01;
        in_data   = {8'h00, 8'h0E};
        tick;
        check_eq("p4_occ_pre", occ_of(0), 1);
        in_data = {8'h00, 8'h0F};
        #1;
        check_eq("p4_push_pop", {ll_push, ll_push_sel, ll_pop, ll_pop_sel}, 4'b1010);
        tick;
        in_valid = 2'b00;
        check_eq("p4_occ_post", occ_of(0), 1);
        check_eq("p4_not_empty", ll_empty[0], 0);
        check_eq("p4_out", out_data, 8'h0E);

        // Phase 5: asynchronous reset mid-traffic with out_valid=1.
        in_valid = 2'b11;
        in_data  = {8'h22, 8'h11};
        #1;
        rst = 1'b0;
        #1;
        check_eq("ar_out_valid", out_valid, 0);
        check_eq("ar_out_data", out_data, 0);
        check_eq("ar_occ", occ, 0);
        check_eq("ar_in_ready", in_ready, 0);
        check_eq("ar_ll_push", ll_push, 0);
        #3;
        rst = 1'b1;
        #1;
        // push_ptr was 1 before reset; a reset pointer grants queue 0 first.
        check_eq("ar_push_ptr0", in_ready, 2'b01);
        tick;
        check_eq("ar_push_next", in_ready, 2'b10);
        check_eq("ar_pop_sel", {ll_pop, ll_pop_sel}, 2'b10);
        in_valid = 2'b00;
        tick;
        check_eq("ar_out_after", {out_valid, out_data}, {1'b1, 8'h11});
        repeat (3) tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
